// File: rtl/miner_pkg.sv
// Shared SHA-256 constants, word type and small-sigma helpers for the miner core.
package miner_pkg;
  localparam int WORD_W    = 32;
  localparam int MSA_WORDS = 64;
  localparam int CHUNK_W   = 512;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t ssig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
endpackage

// File: rtl/miner_msa_sigma.sv
// Shared schedule-extension datapath: s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16].
module miner_msa_sigma
  import miner_pkg::*;
(
  input  word_t wm2,
  input  word_t wm7,
  input  word_t wm15,
  input  word_t wm16,
  output word_t wnew
);
  assign wnew = ssig1(wm2) + wm7 + ssig0(wm15) + wm16;
endmodule

// File: rtl/miner_core_msa.sv
// SHA-256 message schedule array: one-cycle 16-word load, then one extended word per enabled cycle.
module miner_core_msa
  import miner_pkg::*;
(
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic [0:6]                         i,
  input  logic                               msa_en,
  input  logic [0:CHUNK_W-1]                 chunk,
  output logic [0:MSA_WORDS-1][0:WORD_W-1]   w
);
  logic [0:MSA_WORDS-1][0:WORD_W-1] w_q, w_d;
  logic [5:0] idx;
  logic       in_range, do_load, do_ext;
  word_t      wnew;

  // i[0] is the MSB, so it alone flags indices 64..127
  assign idx      = i[1:6];
  assign in_range = ~i[0];
  assign do_load  = msa_en & in_range & (idx < 6'd16);
  assign do_ext   = msa_en & in_range & (idx >= 6'd16);

  miner_msa_sigma u_sigma (
    .wm2  (w_q[idx - 6'd2]),
    .wm7  (w_q[idx - 6'd7]),
    .wm15 (w_q[idx - 6'd15]),
    .wm16 (w_q[idx - 6'd16]),
    .wnew (wnew)
  );

  always_comb begin
    w_d = w_q;
    if (do_load) begin
      for (int k = 0; k < 16; k++) w_d[k] = chunk[WORD_W*k +: WORD_W];
    end else if (do_ext) begin
      w_d[idx] = wnew;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) w_q <= '0;
    else        w_q <= w_d;
  end

  assign w = w_q;
endmodule

// File: tb/tb_miner_core_msa.sv
// Self-checking bench for miner_core_msa against a behavioural SHA-256 schedule model.
module tb_miner_core_msa;
  logic             clk = 1'b0;
  logic             n_rst;
  logic [0:6]       i;
  logic             msa_en;
  logic [0:511]     chunk;
  logic [0:63][0:31] w;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_w [64];
  logic [31:0] snap  [64];
  logic [0:511] abc;

  miner_core_msa dut (
    .clk(clk), .n_rst(n_rst), .i(i), .msa_en(msa_en), .chunk(chunk), .w(w)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0m(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1m(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [0:511] rand_chunk();
    logic [0:511] c;
    for (int k = 0; k < 16; k++) c[32*k +: 32] = $urandom;
    return c;
  endfunction

  // Drive one clock edge and advance the reference model by the same rules.
  task automatic cyc(input logic r, input logic en, input int idx, input logic [0:511] ch);
    logic [6:0] iv;
    iv = idx[6:0];
    n_rst = r; msa_en = en; i = iv; chunk = ch;
    if (!r) begin
      for (int k = 0; k < 64; k++) exp_w[k] = 32'h0;
    end else if (en && idx < 16) begin
      for (int k = 0; k < 16; k++) exp_w[k] = ch[32*k +: 32];
    end else if (en && idx < 64) begin
      exp_w[idx] = s1m(exp_w[idx-2]) + exp_w[idx-7] + s0m(exp_w[idx-15]) + exp_w[idx-16];
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b1, $urandom_range(0, 127), rand_chunk());
    cyc(1'b0, 1'b1, $urandom_range(0, 15), rand_chunk());
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (w[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset w[%0d] got %h exp 00000000", k, w[k]);
      end
    end
  endtask

  task automatic test_numeric();
    cyc(1'b1, 1'b1, 15, 512'd1238290);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (w[k] !== ((k == 15) ? 32'h0012E512 : 32'h0)) begin
        failures++;
        $display("FAIL numeric_load w[%0d] got %h", k, w[k]);
      end
    end
    cyc(1'b1, 1'b1, 16, rand_chunk());
    checks++;
    if (w[16] !== 32'h0) begin
      failures++;
      $display("FAIL numeric_w16 got %h exp 00000000", w[16]);
    end
  endtask

  task automatic test_enable_low();
    cyc(1'b0, 1'b0, 0, rand_chunk());
    cyc(1'b1, 1'b1, 3, abc);
    for (int idx = 16; idx < 64; idx++) cyc(1'b1, 1'b0, idx, rand_chunk());
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (w[k] !== ((k < 16) ? abc[32*k +: 32] : 32'h0)) begin
        failures++;
        $display("FAIL enable_low w[%0d] got %h", k, w[k]);
      end
    end
  endtask

  task automatic test_abc();
    for (int idx = 16; idx < 64; idx++) cyc(1'b1, 1'b1, idx, rand_chunk());
    checks++;
    if (w[16] !== 32'h61626380 || w[17] !== 32'h000F0000 || w[18] !== 32'h7DA86405) begin
      failures++;
      $display("FAIL abc_known got %h %h %h exp 61626380 000f0000 7da86405", w[16], w[17], w[18]);
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (w[k] !== exp_w[k]) begin
        failures++;
        $display("FAIL abc_sched w[%0d] got %h exp %h", k, w[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < 64; k++) snap[k] = exp_w[k];
    for (int idx = 64; idx < 128; idx++) cyc(1'b1, 1'b1, idx, rand_chunk());
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (w[k] !== snap[k]) begin
        failures++;
        $display("FAIL out_of_range w[%0d] got %h exp %h", k, w[k], snap[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b1, 0, rand_chunk());
    for (int idx = 16; idx < 40; idx++) cyc(1'b1, 1'b1, idx, rand_chunk());
    cyc(1'b0, 1'b1, 40, rand_chunk());
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (w[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset_mid w[%0d] got %h exp 00000000", k, w[k]);
      end
    end
    cyc(1'b1, 1'b1, 9, rand_chunk());
    for (int idx = 16; idx < 64; idx++) cyc(1'b1, 1'b1, idx, rand_chunk());
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (w[k] !== exp_w[k]) begin
        failures++;
        $display("FAIL reload_sched w[%0d] got %h exp %h", k, w[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_random_chunks();
    for (int n = 0; n < 4; n++) begin
      cyc(1'b1, 1'b1, $urandom_range(0, 15), rand_chunk());
      for (int idx = 16; idx < 64; idx++) cyc(1'b1, 1'b1, idx, rand_chunk());
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (w[k] !== exp_w[k]) begin
          failures++;
          $display("FAIL random_sched%0d w[%0d] got %h exp %h", n, k, w[k], exp_w[k]);
        end
      end
    end
  endtask

  initial begin
    abc = {32'h61626380, 448'h0, 32'h00000018};
    n_rst = 1'b0; msa_en = 1'b0; i = '0; chunk = '0;
    test_reset();
    test_numeric();
    test_enable_low();
    test_abc();
    test_out_of_range();
    test_reset_mid();
    test_random_chunks();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
